// File: rtl/sram_bist_ctrl_if.sv
// Pin bundle between the BIST engine and one asynchronous SRAM bank.
// The master side drives address, data and strobes; the slave side returns pad read data.
interface sram_bist_ctrl_if #(
  parameter int unsigned ADDR_W = 18,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NBE    = DATA_W / 8
);
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_dq_o;
  logic              sram_dq_oe;
  logic [DATA_W-1:0] sram_dq_i;
  logic              sram_ce_n;
  logic              sram_oe_n;
  logic              sram_we_n;
  logic [NBE-1:0]    sram_be_n;

  modport master (
    output sram_addr, sram_dq_o, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_be_n,
    input  sram_dq_i
  );

  modport slave (
    input  sram_addr, sram_dq_o, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_be_n,
    output sram_dq_i
  );
endinterface

// File: rtl/sram_bist_ctrl.sv
// Built-in self-test engine for one external asynchronous SRAM bank: writes and/or verifies a
// regenerable data pattern over the whole address space and collects error statistics.
module sram_bist_ctrl #(
  parameter int unsigned ADDR_W   = 18,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned WAIT_CYC = 2,
  parameter int unsigned NBE      = DATA_W / 8
) (
  input  logic              SYS_CLK,
  input  logic              SYS_RST,
  input  logic              cmd_start,
  input  logic              cmd_abort,
  input  logic [1:0]        cmd_mode,
  input  logic [1:0]        pattern_sel,
  input  logic [DATA_W-1:0] seed,
  input  logic [NBE-1:0]    be_mask,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       err_cnt,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data,
  sram_bist_ctrl_if.master  sram
);

  localparam int unsigned       PhW      = $clog2(WAIT_CYC + 1);
  localparam logic [PhW-1:0]    PhLast   = PhW'(WAIT_CYC);
  localparam logic [ADDR_W-1:0] AddrLast = '1;

  typedef enum logic [2:0] {StIdle, StWr, StRd, StFlush, StFin} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [PhW-1:0]    ph_q, ph_d;
  logic              wr_only_q, wr_only_d;
  logic [1:0]        sel_q, sel_d;
  logic [DATA_W-1:0] seed_q, seed_d;
  logic [NBE-1:0]    be_q, be_d;
  logic [15:0]       err_q, err_d;
  logic [ADDR_W-1:0] faddr_q, faddr_d;
  logic [DATA_W-1:0] fdata_q, fdata_d;
  logic              pass_q, pass_d;
  logic [DATA_W-1:0] rd_q, rd_d;
  logic [ADDR_W-1:0] cmp_addr_q, cmp_addr_d;
  logic              cmp_vld_q, cmp_vld_d;

  logic [DATA_W-1:0] lane_mask;
  logic              abort;
  logic              mismatch;

  // Pattern is a pure function of the address so the verify pass can regenerate it.
  function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a,
                                                input logic [1:0]        sel,
                                                input logic [DATA_W-1:0] sd);
    logic [DATA_W-1:0] one;
    logic [DATA_W-1:0] res;
    one    = '0;
    one[0] = 1'b1;
    case (sel)
      2'd0:    res = sd;
      2'd1:    res = DATA_W'(a) ^ sd;
      2'd2:    res = one << (32'(a) % DATA_W);
      default: res = a[0] ? ~sd : sd;
    endcase
    return res;
  endfunction

  always_comb begin
    lane_mask = '0;
    for (int i = 0; i < int'(NBE); i++) begin
      lane_mask[8*i +: 8] = {8{be_q[i]}};
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    ph_d       = ph_q;
    wr_only_d  = wr_only_q;
    sel_d      = sel_q;
    seed_d     = seed_q;
    be_d       = be_q;
    err_d      = err_q;
    faddr_d    = faddr_q;
    fdata_d    = fdata_q;
    pass_d     = pass_q;
    rd_d       = rd_q;
    cmp_addr_d = cmp_addr_q;
    cmp_vld_d  = 1'b0;

    abort    = cmd_abort && (state_q inside {StWr, StRd, StFlush});
    mismatch = cmp_vld_q &&
               (((rd_q ^ pattern(cmp_addr_q, sel_q, seed_q)) & lane_mask) != '0);

    // Compare of the previous read word overlaps the current word; an abort discards it.
    if (mismatch && !abort) begin
      if (err_q == '0) begin
        faddr_d = cmp_addr_q;
        fdata_d = rd_q & lane_mask;
      end
      if (err_q != 16'hFFFF) begin
        err_d = err_q + 16'd1;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (cmd_start) begin
          sel_d     = pattern_sel;
          seed_d    = seed;
          be_d      = be_mask;
          wr_only_d = (cmd_mode == 2'd0);
          err_d     = '0;
          faddr_d   = '0;
          fdata_d   = '0;
          pass_d    = 1'b0;
          addr_d    = '0;
          ph_d      = '0;
          state_d   = (cmd_mode == 2'd1) ? StRd : StWr;
        end
      end
      StWr: begin
        if (abort) begin
          state_d = StFin;
          pass_d  = 1'b0;
          addr_d  = '0;
          ph_d    = '0;
        end else if (ph_q == PhLast) begin
          ph_d = '0;
          if (addr_q == AddrLast) begin
            addr_d = '0;
            if (wr_only_q) begin
              state_d = StFin;
              pass_d  = (err_d == '0);
            end else begin
              state_d = StRd;
            end
          end else begin
            addr_d = addr_q + ADDR_W'(1);
          end
        end else begin
          ph_d = ph_q + PhW'(1);
        end
      end
      StRd: begin
        if (abort) begin
          state_d = StFin;
          pass_d  = 1'b0;
          addr_d  = '0;
          ph_d    = '0;
        end else if (ph_q == PhLast) begin
          ph_d       = '0;
          rd_d       = sram.sram_dq_i;
          cmp_addr_d = addr_q;
          cmp_vld_d  = 1'b1;
          if (addr_q == AddrLast) begin
            addr_d  = '0;
            state_d = StFlush;
          end else begin
            addr_d = addr_q + ADDR_W'(1);
          end
        end else begin
          ph_d = ph_q + PhW'(1);
        end
      end
      StFlush: begin
        state_d = StFin;
        pass_d  = !abort && (err_d == '0);
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge SYS_CLK) begin
    if (SYS_RST) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      ph_q       <= '0;
      wr_only_q  <= 1'b0;
      sel_q      <= '0;
      seed_q     <= '0;
      be_q       <= '0;
      err_q      <= '0;
      faddr_q    <= '0;
      fdata_q    <= '0;
      pass_q     <= 1'b0;
      rd_q       <= '0;
      cmp_addr_q <= '0;
      cmp_vld_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      ph_q       <= ph_d;
      wr_only_q  <= wr_only_d;
      sel_q      <= sel_d;
      seed_q     <= seed_d;
      be_q       <= be_d;
      err_q      <= err_d;
      faddr_q    <= faddr_d;
      fdata_q    <= fdata_d;
      pass_q     <= pass_d;
      rd_q       <= rd_d;
      cmp_addr_q <= cmp_addr_d;
      cmp_vld_q  <= cmp_vld_d;
    end
  end

  assign busy      = state_q inside {StWr, StRd, StFlush};
  assign done      = (state_q == StFin);
  assign pass      = pass_q;
  assign err_cnt   = err_q;
  assign fail_addr = faddr_q;
  assign fail_data = fdata_q;

  // Strobes decode straight from state so they are parked high outside WR/RD.
  always_comb begin
    sram.sram_addr  = '0;
    sram.sram_dq_o  = '0;
    sram.sram_dq_oe = 1'b0;
    sram.sram_ce_n  = 1'b1;
    sram.sram_oe_n  = 1'b1;
    sram.sram_we_n  = 1'b1;
    sram.sram_be_n  = '1;
    if (state_q == StWr) begin
      sram.sram_addr  = addr_q;
      sram.sram_dq_o  = pattern(addr_q, sel_q, seed_q);
      sram.sram_dq_oe = 1'b1;
      sram.sram_ce_n  = 1'b0;
      sram.sram_we_n  = (ph_q == '0);
      sram.sram_be_n  = ~be_q;
    end else if (state_q == StRd) begin
      sram.sram_addr = addr_q;
      sram.sram_ce_n = 1'b0;
      sram.sram_oe_n = 1'b0;
      sram.sram_be_n = ~be_q;
    end
  end

endmodule

// File: tb/tb_sram_bist_ctrl.sv
// Directed bench for sram_bist_ctrl with a behavioural byte-enabled SRAM and injectable faults.
module tb_sram_bist_ctrl;
  localparam int unsigned AW = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned WC = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_start, cmd_abort;
  logic [1:0]  cmd_mode, pattern_sel;
  logic [31:0] seed;
  logic [3:0]  be_mask;
  logic        busy, done, pass;
  logic [15:0] err_cnt;
  logic [3:0]  fail_addr;
  logic [31:0] fail_data;

  always #5 clk = ~clk;

  sram_bist_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) sif ();

  sram_bist_ctrl #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYC(WC)) dut (
    .SYS_CLK     (clk),
    .SYS_RST     (rst),
    .cmd_start   (cmd_start),
    .cmd_abort   (cmd_abort),
    .cmd_mode    (cmd_mode),
    .pattern_sel (pattern_sel),
    .seed        (seed),
    .be_mask     (be_mask),
    .busy        (busy),
    .done        (done),
    .pass        (pass),
    .err_cnt     (err_cnt),
    .fail_addr   (fail_addr),
    .fail_data   (fail_data),
    .sram        (sif.master)
  );

  // SRAM model: 0 none, 1 bit5 of addr 7 reads 0, 2 byte 3 inverted on read, 3 reads all zero
  logic [31:0] mem [16];
  int          fault = 0;
  logic [31:0] rdv;

  always @(negedge clk) begin
    if (!sif.sram_ce_n && !sif.sram_we_n) begin
      for (int b = 0; b < 4; b++) begin
        if (!sif.sram_be_n[b]) mem[sif.sram_addr][8*b +: 8] <= sif.sram_dq_o[8*b +: 8];
      end
    end
  end

  always_comb begin
    rdv = mem[sif.sram_addr];
    case (fault)
      1: if (sif.sram_addr == 4'd7) rdv[5] = 1'b0;
      2: rdv[31:24] = ~rdv[31:24];
      3: rdv = '0;
      default: ;
    endcase
    sif.sram_dq_i = (!sif.sram_ce_n && !sif.sram_oe_n) ? rdv : '0;
  end

  int pcnt = 0;
  always @(posedge clk) pcnt <= pcnt + 1;

  typedef struct {
    int          lat;
    logic        pass;
    logic [15:0] err;
    logic [3:0]  faddr;
    logic [31:0] fdata;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   t0;
  int   wr_cyc, we_lo, oe_lo, be_bad, done_cnt;
  logic [3:0] be_exp;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (!sif.sram_ce_n && sif.sram_dq_oe) begin
      wr_cyc++;
      if (!sif.sram_we_n) we_lo++;
    end
    if (!sif.sram_oe_n) oe_lo++;
    if (!sif.sram_ce_n && (sif.sram_be_n !== be_exp)) be_bad++;
    if (done) done_cnt++;
  endtask

  task automatic start_run(input logic [1:0] mode, input logic [1:0] psel, input logic [31:0] sd,
                           input logic [3:0] be, input bit push, input exp_t e);
    @(negedge clk);
    cmd_mode    = mode;
    pattern_sel = psel;
    seed        = sd;
    be_mask     = be;
    cmd_start   = 1'b1;
    t0          = pcnt;
    wr_cyc = 0; we_lo = 0; oe_lo = 0; be_bad = 0; done_cnt = 0;
    if (push) sbq.push_back(e);
    step();
    cmd_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int   n = 0;
    int   lat;
    exp_t e;
    while (!done && n < budget) begin
      step();
      n++;
    end
    lat = pcnt - t0;
    chk({tag, ".done"}, 64'(done), 64'(1));
    chk({tag, ".busy"}, 64'(busy), 64'(0));
    if (sbq.size() == 0) begin
      chk({tag, ".sbq"}, 64'(sbq.size()), 64'(1));
    end else begin
      e = sbq.pop_front();
      chk({tag, ".lat"},   64'(lat),       64'(e.lat));
      chk({tag, ".pass"},  64'(pass),      64'(e.pass));
      chk({tag, ".err"},   64'(err_cnt),   64'(e.err));
      chk({tag, ".faddr"}, 64'(fail_addr), 64'(e.faddr));
      chk({tag, ".fdata"}, 64'(fail_data), 64'(e.fdata));
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, ".busy"},  64'(busy),           64'(0));
    chk({tag, ".done"},  64'(done),           64'(0));
    chk({tag, ".pass"},  64'(pass),           64'(0));
    chk({tag, ".err"},   64'(err_cnt),        64'(0));
    chk({tag, ".faddr"}, 64'(fail_addr),      64'(0));
    chk({tag, ".fdata"}, 64'(fail_data),      64'(0));
    chk({tag, ".addr"},  64'(sif.sram_addr),  64'(0));
    chk({tag, ".dq_o"},  64'(sif.sram_dq_o),  64'(0));
    chk({tag, ".dq_oe"}, 64'(sif.sram_dq_oe), 64'(0));
    chk({tag, ".ce_n"},  64'(sif.sram_ce_n),  64'(1));
    chk({tag, ".oe_n"},  64'(sif.sram_oe_n),  64'(1));
    chk({tag, ".we_n"},  64'(sif.sram_we_n),  64'(1));
    chk({tag, ".be_n"},  64'(sif.sram_be_n),  64'(4'hF));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=hang expected=finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; cmd_start = 1'b0; cmd_abort = 1'b0;
    cmd_mode = '0; pattern_sel = '0; seed = '0; be_mask = '0; be_exp = 4'hF;
    repeat (3) @(negedge clk);
    chk_reset_outs("rst0");
    rst = 1'b0;
    step();

    // 1: write then verify, constant seed, fault-free
    fault = 0; be_exp = 4'hF;
    start_run(2'd2, 2'd0, 32'h1122_3344, 4'hF, 1'b1, '{98, 1'b1, 16'd0, 4'd0, 32'd0});
    wait_done("t1", 300);
    chk("t1.wr_cyc", 64'(wr_cyc), 64'(48));
    chk("t1.we_lo",  64'(we_lo),  64'(32));
    for (int a = 0; a < 16; a++) chk($sformatf("t1.mem%0d", a), 64'(mem[a]), 64'(32'h1122_3344));

    // 2: single stuck-low bit at address 7
    fault = 1;
    start_run(2'd2, 2'd0, 32'hFFFF_FFFF, 4'hF, 1'b1, '{98, 1'b0, 16'd1, 4'd7, 32'hFFFF_FFDF});
    wait_done("t2", 300);

    // 3: only lane 0 tested, lane 3 corrupted everywhere
    fault = 2; be_exp = 4'b1110;
    start_run(2'd2, 2'd1, 32'h1234_5678, 4'h1, 1'b1, '{98, 1'b1, 16'd0, 4'd0, 32'd0});
    wait_done("t3", 300);
    chk("t3.be_bad", 64'(be_bad), 64'(0));
    chk("t3.oe_lo",  64'(oe_lo),  64'(48));

    // 4: write-only walking one
    fault = 0; be_exp = 4'hF;
    start_run(2'd0, 2'd2, 32'h0, 4'hF, 1'b1, '{49, 1'b1, 16'd0, 4'd0, 32'd0});
    wait_done("t4", 300);
    chk("t4.mem9",   64'(mem[9]), 64'(32'h0000_0200));
    chk("t4.mem3",   64'(mem[3]), 64'(32'h0000_0008));
    chk("t4.oe_lo",  64'(oe_lo),  64'(0));
    chk("t4.wr_cyc", 64'(wr_cyc), 64'(48));

    // 5: start while busy is ignored; abort at setup cycle of WR word 5
    start_run(2'd2, 2'd0, 32'hCAFE_F00D, 4'hF, 1'b1, '{17, 1'b0, 16'd0, 4'd0, 32'd0});
    repeat (4) step();
    cmd_start = 1'b1;
    step();
    cmd_start = 1'b0;
    repeat (10) step();
    chk("t5.addr5", 64'(sif.sram_addr),  64'(5));
    chk("t5.setup", 64'(sif.sram_we_n),  64'(1));
    chk("t5.wr_oe", 64'(sif.sram_dq_oe), 64'(1));
    cmd_abort = 1'b1;
    step();
    cmd_abort = 1'b0;
    chk("t5.ce_n",  64'(sif.sram_ce_n),  64'(1));
    chk("t5.we_n",  64'(sif.sram_we_n),  64'(1));
    chk("t5.dq_oe", 64'(sif.sram_dq_oe), 64'(0));
    wait_done("t5", 5);
    repeat (110) step();
    chk("t5.done_cnt", 64'(done_cnt), 64'(1));

    // 6: verify-only against all-zero memory, reset mid-run, then a clean run
    fault = 3;
    start_run(2'd1, 2'd3, 32'h00FF_00FF, 4'hF, 1'b0, '{0, 1'b0, 16'd0, 4'd0, 32'd0});
    repeat (30) step();
    chk("t6.busy",  64'(busy),          64'(1));
    chk("t6.addr",  64'(sif.sram_addr), 64'(10));
    chk("t6.oe_n",  64'(sif.sram_oe_n), 64'(0));
    chk("t6.err",   64'(err_cnt),       64'(9));
    chk("t6.faddr", 64'(fail_addr),     64'(0));
    chk("t6.fdata", 64'(fail_data),     64'(0));
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_reset_outs("t6rst");
    step();
    fault = 0;
    start_run(2'd2, 2'd1, 32'hA5A5_0000, 4'hF, 1'b1, '{98, 1'b1, 16'd0, 4'd0, 32'd0});
    wait_done("t6b", 300);
    chk("t6b.mem12", 64'(mem[12]), 64'(32'hA5A5_000C));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
